// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority voting, parity/framing flags and break handling
module uart_rx_param #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Rx_Pin_In,
    input  logic                 Rx_En_Sig,
    output logic                 Rx_Done_Sig,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Parity_Err_Sig,
    output logic                 Frame_Err_Sig,
    output logic                 Busy_Sig
);
    localparam int CW  = $clog2(CLK_DIV);
    localparam int MID = CLK_DIV / 2;
    localparam logic [CW-1:0] LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] AT_S0  = CW'(MID - 1);
    localparam logic [CW-1:0] AT_S1  = CW'(MID);
    localparam logic [CW-1:0] AT_MAJ = CW'(MID + 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BREAK_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 sync_q, rxs_q, prev_q;
    logic [CW-1:0]        bcnt_q, bcnt_d;
    logic [3:0]           idx_q, idx_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
    logic                 at_maj, at_end, maj, fall;

    assign at_maj = bcnt_q == AT_MAJ;
    assign at_end = bcnt_q == LAST;
    // the third sample is the live synchronised value at MID+1
    assign maj    = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign fall   = prev_q & ~rxs_q;

    assign Rx_Done_Sig    = state_q == DONE;
    assign Busy_Sig       = state_q != IDLE && state_q != BREAK_WAIT;
    assign Rx_Data        = data_q;
    assign Parity_Err_Sig = perr_out_q;
    assign Frame_Err_Sig  = ferr_out_q;

    // two-flop synchroniser plus a history flop for falling-edge detection; idles high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= Rx_Pin_In;
            rxs_q  <= sync_q;
            prev_q <= rxs_q;
        end
    end

    // frame state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // bit timing, sample, shift and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bcnt_q     <= '0;
            idx_q      <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            shreg_q    <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            bcnt_q     <= bcnt_d;
            idx_q      <= idx_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    // next-state and datapath; the last stop bit exits at its vote so a back-to-back start is not missed
    always_comb begin
        state_d    = state_q;
        bcnt_d     = at_end ? '0 : bcnt_q + CW'(1);
        idx_d      = idx_q;
        s0_d       = (bcnt_q == AT_S0) ? rxs_q : s0_q;
        s1_d       = (bcnt_q == AT_S1) ? rxs_q : s1_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        case (state_q)
            IDLE: if (Rx_En_Sig && fall) begin
                state_d = START;
                bcnt_d  = '0;
                idx_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
            START: begin
                if (at_maj && maj) state_d = IDLE;
                else if (at_end)   state_d = DATA;
            end
            DATA: begin
                if (at_maj) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (at_end) begin
                    idx_d = (idx_q == LAST_DATA) ? 4'd0 : idx_q + 4'd1;
                    if (idx_q == LAST_DATA) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_maj) perr_d = ^shreg_q ^ maj ^ 1'(PARITY_ODD);
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_maj) begin
                    ferr_d = ferr_q | ~maj;
                    if (idx_q == LAST_STOP) begin
                        state_d    = DONE;
                        data_d     = shreg_q;
                        perr_out_d = perr_q;
                        ferr_out_d = ferr_q | ~maj;
                    end
                end
                if (at_end) idx_d = idx_q + 4'd1;
            end
            DONE:       state_d = rxs_q ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rxs_q) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench over three receiver configurations (8N1, 8E1, 5N2)
module tb_uart_rx_param;
    localparam int CD = 16;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pin = 3'b111;
    logic [2:0] en = 3'b111;
    logic [2:0] done, busy, perr, ferr;
    logic [7:0] data_a, data_b;
    logic [4:0] data_c;
    logic [8:0] dat [3];

    int nb_c [3] = '{8, 8, 5};
    int pe_c [3] = '{0, 1, 0};
    int sb_c [3] = '{1, 1, 2};

    exp_t q[$];
    int total = 0, bad = 0, cyc = 0;
    int rise_cyc [3] = '{0, 0, 0};
    logic [2:0] busy_prev = 3'b000, done_prev = 3'b000;
    int req_seq = 0, seen_seq = 0, req_type = 0, req_inst = 0;

    always #5 clk = ~clk;

    assign dat[0] = {1'b0, data_a};
    assign dat[1] = {1'b0, data_b};
    assign dat[2] = {4'b0, data_c};

    uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .CLK(clk), .RST(rst), .Rx_Pin_In(pin[0]), .Rx_En_Sig(en[0]), .Rx_Done_Sig(done[0]),
        .Rx_Data(data_a), .Parity_Err_Sig(perr[0]), .Frame_Err_Sig(ferr[0]), .Busy_Sig(busy[0]));
    uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .CLK(clk), .RST(rst), .Rx_Pin_In(pin[1]), .Rx_En_Sig(en[1]), .Rx_Done_Sig(done[1]),
        .Rx_Data(data_b), .Parity_Err_Sig(perr[1]), .Frame_Err_Sig(ferr[1]), .Busy_Sig(busy[1]));
    uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
        .CLK(clk), .RST(rst), .Rx_Pin_In(pin[2]), .Rx_En_Sig(en[2]), .Rx_Done_Sig(done[2]),
        .Rx_Data(data_c), .Parity_Err_Sig(perr[2]), .Frame_Err_Sig(ferr[2]), .Busy_Sig(busy[2]));

    // expected frame result straight from the line bits: masked word, even-parity count, any low stop bit
    function automatic exp_t model(input int inst, input logic [8:0] w, input logic pbit, input logic [1:0] stops);
        exp_t e;
        e.inst = inst;
        e.data = w & 9'((1 << nb_c[inst]) - 1);
        e.perr = (pe_c[inst] != 0) && ((($countones(e.data) + int'(pbit)) % 2) != 0);
        e.ferr = 1'b0;
        for (int i = 0; i < sb_c[inst]; i++) if (!stops[i]) e.ferr = 1'b1;
        return e;
    endfunction

    function automatic int latency(input int inst);
        return (nb_c[inst] + pe_c[inst] + sb_c[inst]) * CD + CD / 2 + 2;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, inst, got, want, $time);
        end
    endtask

    // monitor: every done pops the scoreboard; also services quiet/reset/drain check requests
    always @(negedge clk) begin
        exp_t e;
        if (req_seq != seen_seq) begin
            case (req_type)
                1: chk("idle_quiet", req_inst, 32'({busy[req_inst], done[req_inst]}), 0);
                2: for (int i = 0; i < 3; i++)
                       chk("reset_zero", i, 32'({busy[i], done[i], perr[i], ferr[i], dat[i]}), 0);
                default: chk("queue_drained", 0, 32'(q.size()), 0);
            endcase
            seen_seq = req_seq;
        end
        for (int i = 0; i < 3; i++) begin
            if (busy[i] && !busy_prev[i]) rise_cyc[i] = cyc;
            if (done[i]) begin
                chk("done_twice", i, 32'(done_prev[i]), 0);
                chk("done_expected", i, 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("instance", i, i, e.inst);
                    chk("data", i, 32'(dat[i]), 32'(e.data));
                    chk("parity_err", i, 32'(perr[i]), 32'(e.perr));
                    chk("frame_err", i, 32'(ferr[i]), 32'(e.ferr));
                    chk("latency", i, cyc - rise_cyc[i], latency(i));
                end
            end
            busy_prev[i] = busy[i];
            done_prev[i] = done[i];
        end
        cyc++;
    end

    task automatic hold(input int inst, input logic v, input int n);
        pin[inst] = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drive one frame; optional single-cycle glitch, enable drop and reset abort at given cycle offsets
    task automatic send(input int inst, input logic [8:0] w, input logic pbit, input logic [1:0] stops,
                        input bit expect_it, input int glitch_p, input int drop_p, input int abort_p);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nb_c[inst]; i++) bits.push_back(w[i]);
        if (pe_c[inst] != 0) bits.push_back(pbit);
        for (int i = 0; i < sb_c[inst]; i++) bits.push_back(stops[i]);
        if (expect_it) q.push_back(model(inst, w, pbit, stops));
        for (int p = 0; p < bits.size() * CD; p++) begin
            if (p == abort_p) begin
                rst = 1'b1;
                pin[inst] = 1'b1;
                req_type = 2;
                req_seq++;
                @(posedge clk);
                #1;
                rst = 1'b0;
                break;
            end
            if (p == drop_p) en[inst] = 1'b0;
            pin[inst] = bits[p / CD] ^ (p == glitch_p);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [8:0] w;
        logic       pb;
        logic [1:0] st;
        int         g;
        repeat (3) @(posedge clk);
        #1;
        req_type = 2;
        req_seq++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(0, 1'b1, 20);
        send(0, 9'hA5, 1'b0, 2'b11, 1'b1, -1, -1, -1);
        send(0, 9'h3C, 1'b0, 2'b11, 1'b1, -1, -1, -1);
        hold(0, 1'b1, 40);
        q.push_back(model(0, 9'h000, 1'b0, 2'b00));
        hold(0, 1'b0, 3 * 10 * CD);
        hold(0, 1'b1, 40);
        send(0, 9'h55, 1'b0, 2'b11, 1'b1, -1, -1, -1);
        hold(0, 1'b1, 30);
        hold(0, 1'b0, 4);
        hold(0, 1'b1, 40);
        req_type = 1;
        req_inst = 0;
        req_seq++;
        hold(0, 1'b1, 2);
        send(0, 9'h5A, 1'b0, 2'b11, 1'b1, 4 * CD + CD / 2 + 1, -1, -1);
        hold(0, 1'b1, 20);
        en[0] = 1'b0;
        send(0, 9'h99, 1'b0, 2'b11, 1'b0, -1, -1, -1);
        hold(0, 1'b1, 20);
        en[0] = 1'b1;
        hold(0, 1'b1, 5);
        send(0, 9'hE7, 1'b0, 2'b11, 1'b1, -1, 60, -1);
        en[0] = 1'b1;
        hold(0, 1'b1, 20);
        send(0, 9'hC3, 1'b0, 2'b11, 1'b0, -1, -1, 3 * CD + 5);
        hold(0, 1'b1, 30);
        send(0, 9'h81, 1'b0, 2'b11, 1'b1, -1, -1, -1);
        hold(0, 1'b1, 20);
        send(1, 9'h07, 1'b1, 2'b11, 1'b1, -1, -1, -1);
        send(1, 9'h07, 1'b0, 2'b11, 1'b1, -1, -1, -1);
        hold(1, 1'b1, 20);
        send(2, 9'h1B, 1'b0, 2'b11, 1'b1, -1, -1, -1);
        hold(2, 1'b1, 10);
        send(2, 9'h1B, 1'b0, 2'b01, 1'b1, -1, -1, -1);
        hold(2, 1'b1, 30);
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 8; n++) begin
                w  = 9'($urandom);
                pb = 1'($urandom);
                st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                g  = ($urandom_range(0, 1) != 0) ? (1 + int'($urandom_range(0, nb_c[i] - 1))) * CD + CD / 2 + 1 : -1;
                send(i, w, pb, st, 1'b1, g, -1, -1);
                if (st[sb_c[i] - 1]) hold(i, 1'b1, ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 30)));
                else hold(i, 1'b1, 20 + int'($urandom_range(0, 20)));
            end
            hold(i, 1'b1, 30);
        end
        for (int t = 0; t < 3000 && q.size() != 0; t++) @(posedge clk);
        #1;
        req_type = 3;
        req_seq++;
        @(posedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8N1 UART receive path. One module combines the input synchroniser, start-edge detect, bit-rate counter and frame control.
- Adds the following:
  - configurable data width, parity and stop-bit count;
  - 3-sample majority voting at each bit centre;
  - false-start rejection;
  - parity and framing error flags;
  - break handling.
- Sits between the Rx pin and the byte consumer, such as a FIFO or command decoder.

Parameters:
- CLK_DIV, 434: CLK cycles per bit. 434 gives 115200 baud at 50 MHz. Legal range is 8 or more.
- DATA_BITS, 8: data bits per frame. Legal range is 5 to 9.
- PARITY_EN, 0: 1 enables a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- Rx_Pin_In  in  1  serial line. Asynchronous; idles high.
- Rx_En_Sig  in  1  receive enable. Level sensitive.
- Rx_Done_Sig  out  1  one-cycle pulse when a frame completes.
- Rx_Data  out  DATA_BITS  received word, LSB first on the line. Valid while Rx_Done_Sig is high, and held until the next done.
- Parity_Err_Sig  out  1  parity mismatch for the frame. Valid with Rx_Done_Sig.
- Frame_Err_Sig  out  1  a stop bit was sampled low. Valid with Rx_Done_Sig.
- Busy_Sig  out  1  high from start-edge acceptance until the done cycle, inclusive.

Behaviour:
- Reset values:
  - synchroniser flops are 1;
  - state is IDLE;
  - counters are 0;
  - Rx_Data is 0;
  - Rx_Done_Sig, Parity_Err_Sig, Frame_Err_Sig and Busy_Sig are 0.
- Reset mid-frame aborts the frame immediately, with no done pulse.
- Synchroniser: Rx_Pin_In passes through 2 flops to give `rxs`. A third flop holds the previous value, used for edge detection. All sampling uses `rxs`.
- Bit counter: `bcnt` counts 0..CLK_DIV-1 and wraps. It is cleared on start-edge acceptance.
- Centre sampling:
  - MID = CLK_DIV/2, using integer division.
  - Samples are taken at bcnt = MID-1, MID and MID+1.
  - Bit value is the majority of the three samples, evaluated at MID+1.
  - Bit boundary is at bcnt = CLK_DIV-1.
- State IDLE:
  - Busy_Sig is 0.
  - When Rx_En_Sig=1 and `rxs` shows a falling edge (1 then 0), go to START and clear `bcnt`.
  - While Rx_En_Sig=0, edges are ignored.
- State START:
  - If the majority at MID+1 is 1, the start is false: return to IDLE, with no done and no flags.
  - Otherwise go to DATA at the bit boundary.
- State DATA:
  - Shift the majority bits into a shift register, LSB first.
  - After DATA_BITS bits, go to PARITY if PARITY_EN=1, else to STOP.
- State PARITY:
  - Compute the error flag as XOR of the data bits, XOR the parity bit, XOR PARITY_ODD.
  - A non-zero result is a parity error.
- State STOP:
  - Sample STOP_BITS stop bits. Any sampled 0 sets the framing flag.
  - Go to DONE on the cycle after the last stop bit's MID+1 sample. Do not wait for the bit boundary, so back-to-back frames are caught.
- State DONE (one cycle):
  - Rx_Done_Sig=1.
  - Rx_Data, Parity_Err_Sig and Frame_Err_Sig update in this cycle and hold afterwards.
  - Next state is IDLE if `rxs`=1, else BREAK_WAIT.
- State BREAK_WAIT: stay until `rxs`=1, then go to IDLE. A line held low, such as a break or a stuck line, produces exactly one errored frame and no repeats.
- Rx_En_Sig deasserted mid-frame: the current frame completes normally. Only new starts are inhibited.
- Latency: Rx_Done_Sig rises at (1 + DATA_BITS + PARITY_EN + STOP_BITS - 1) × CLK_DIV + MID + 2 cycles after start-edge acceptance.
- Error flags are frame-local. They are recomputed every frame and never sticky.
- Rx_Done_Sig is never asserted for two consecutive cycles.

Test Plan:
- Clean 8N1 frame: CLK_DIV=16, send 0xA5 then 0x3C back-to-back with one stop bit each. Expect two done pulses, Rx_Data=0xA5 then 0x3C, both flags 0, and the first done exactly 1+8+0+1-1=9 bits ×16 + 8 + 2 = 154 cycles after edge acceptance.
- Parity: PARITY_EN=1, PARITY_ODD=0. Send 0x07 with parity bit 1 and expect Parity_Err_Sig=0. Send 0x07 with parity bit 0 and expect Parity_Err_Sig=1 with Rx_Data=0x07.
- Framing and break: hold the line low for 3 frame times after a start. Expect one done with Rx_Data=0x00 and Frame_Err_Sig=1, then no further done until the line returns high. The next 0x55 frame is received cleanly.
- False start and glitch: a 4-cycle low pulse on Rx_Pin_In produces no done and Busy_Sig returns to 0. A single-cycle inverted glitch at a data-bit centre is voted out and the byte is correct.
- Enable and reset: with Rx_En_Sig=0 a frame is ignored. Drop Rx_En_Sig mid-frame and that frame still completes. Assert RST during DATA: all outputs are 0 immediately, there is no done, and a following 0x81 frame is received correctly.
- Config sweep: DATA_BITS=5 and STOP_BITS=2 with 0x1B: Rx_Data=5'h1B. A low second stop bit gives Frame_Err_Sig=1.
